// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: sole master of the multiplexed RTC bus, serving one register access per grant.
// Define RTC_ARB_RR_EN for round-robin arbitration; fixed priority (lowest index) otherwise.
module rtc_bus_arbiter #(
  parameter int NREQ   = 3,
  parameter int T_ADDR = 4,
  parameter int T_GAP  = 4,
  parameter int T_DATA = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   rnw,
  input  logic [8*NREQ-1:0] addr,
  input  logic [8*NREQ-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        rdata,
  output logic              busy,
  output logic              ad,
  output logic              cs,
  output logic              wr,
  output logic              rd,
  output logic [7:0]        ADout,
  output logic              ADoe,
  input  logic [7:0]        ADin
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  typedef enum logic [3:0] {
    IDLE, A_SEL, A_CS, A_STB, A_DRV, A_RSTB, A_RCS, A_RAD,
    A_REL, GAP, D_CS, D_STB, D_DRV, D_RSTB, D_RCS, DONE
  } state_t;
  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_rnw, r_ad, r_cs, r_wr, r_rd, r_oe;
  logic [7:0]      r_addr, r_wdata, r_adout, r_rdata;
  logic [NREQ-1:0] r_gnt, r_done;
  logic [IW-1:0]   w_win;
  logic            w_any;
  assign w_any = |req;
`ifdef RTC_ARB_RR_EN
  logic [IW-1:0] r_ptr;
  // Scan backwards so the requester closest to the pointer is assigned last and wins.
  always_comb begin
    w_win = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[(int'(r_ptr) + k) % NREQ]) w_win = IW'((int'(r_ptr) + k) % NREQ);
  end
`else
  always_comb begin
    w_win = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[k]) w_win = IW'(k);
  end
`endif
  // The three timed states (A_RSTB, GAP, D_DRV) share r_cnt, preloaded by the state before them.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rnw   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_rdata <= '0;
      r_adout <= '0;
      r_oe    <= 1'b0;
      {r_ad, r_cs, r_wr, r_rd} <= 4'b1111;
`ifdef RTC_ARB_RR_EN
      r_ptr   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_rnw        <= rnw[w_win];
          r_addr       <= addr[8*int'(w_win) +: 8];
          r_wdata      <= wdata[8*int'(w_win) +: 8];
          r_gnt        <= '0;
          r_gnt[w_win] <= 1'b1;
          r_state      <= A_SEL;
`ifdef RTC_ARB_RR_EN
          r_ptr        <= (w_win == IW'(NREQ - 1)) ? '0 : w_win + 1'b1;
`endif
        end
        A_SEL: begin r_ad <= 1'b0; r_state <= A_CS; end
        A_CS:  begin r_cs <= 1'b0; r_state <= A_STB; end
        A_STB: begin r_wr <= 1'b0; r_state <= A_DRV; end
        A_DRV: begin
          r_oe    <= 1'b1;
          r_adout <= r_addr;
          r_cnt   <= 4'(T_ADDR - 1);
          r_state <= A_RSTB;
        end
        A_RSTB: if (r_cnt != 0) r_cnt <= r_cnt - 1'b1;
                else begin r_wr <= 1'b1; r_state <= A_RCS; end
        A_RCS: begin r_cs <= 1'b1; r_state <= A_RAD; end
        A_RAD: begin r_ad <= 1'b1; r_state <= A_REL; end
        A_REL: begin r_oe <= 1'b0; r_cnt <= 4'(T_GAP - 1); r_state <= GAP; end
        GAP: if (r_cnt != 0) r_cnt <= r_cnt - 1'b1;
             else begin r_cs <= 1'b0; r_state <= D_CS; end
        D_CS: begin
          r_rd    <= ~r_rnw;
          r_wr    <= r_rnw;
          r_state <= D_STB;
        end
        D_STB: begin
          if (!r_rnw) begin r_oe <= 1'b1; r_adout <= r_wdata; end
          r_cnt   <= 4'(T_DATA - 1);
          r_state <= D_DRV;
        end
        D_DRV: if (r_cnt != 0) r_cnt <= r_cnt - 1'b1;
               else begin
                 r_wr    <= 1'b1;
                 r_rd    <= 1'b1;
                 r_rdata <= r_rnw ? ADin : r_rdata;
                 r_state <= D_RSTB;
               end
        D_RSTB: begin r_cs <= 1'b1; r_state <= D_RCS; end
        D_RCS: begin
          r_oe    <= 1'b0;
          r_done  <= r_gnt;
          r_gnt   <= '0;
          r_state <= DONE;
        end
        DONE: begin r_done <= '0; r_state <= IDLE; end
      endcase
    end
  end
  assign gnt   = r_gnt;
  assign done  = r_done;
  assign rdata = r_rdata;
  assign busy  = r_state != IDLE;
  assign ad    = r_ad;
  assign cs    = r_cs;
  assign wr    = r_wr;
  assign rd    = r_rd;
  assign ADout = r_adout;
  assign ADoe  = r_oe;
endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// tb_rtc_bus_arbiter: table vectors, hand sequences and random traffic against a transaction-timeline model.
module tb_rtc_bus_arbiter;
  localparam int NREQ = 3, TA = 4, TG = 4, TD = 3, S = TA + TG + TD;
  logic clock = 1'b0, reset = 1'b1;
  always #5 clock = ~clock;
  logic [2:0]  req = '0, rnw = '0, gnt, done;
  logic [23:0] addr = '0, wdata = '0;
  logic [7:0]  adin = '0, rdata, adout;
  logic        busy, ad, cs, wr, rd, adoe;
  logic [2:0]  req1 = '0, rnw1 = '0, gnt1, done1;
  logic [23:0] addr1 = '0, wdata1 = '0;
  logic [7:0]  rdata1, adout1;
  logic        busy1, ad1, cs1, wr1, rd1, adoe1;
  rtc_bus_arbiter #(.NREQ(NREQ), .T_ADDR(TA), .T_GAP(TG), .T_DATA(TD)) dut (
    .clock(clock), .reset(reset), .req(req), .rnw(rnw), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .busy(busy), .ad(ad), .cs(cs), .wr(wr),
    .rd(rd), .ADout(adout), .ADoe(adoe), .ADin(adin));
  rtc_bus_arbiter #(.NREQ(NREQ), .T_ADDR(1), .T_GAP(1), .T_DATA(1)) dut1 (
    .clock(clock), .reset(reset), .req(req1), .rnw(rnw1), .addr(addr1), .wdata(wdata1),
    .gnt(gnt1), .done(done1), .rdata(rdata1), .busy(busy1), .ad(ad1), .cs(cs1), .wr(wr1),
    .rd(rd1), .ADout(adout1), .ADoe(adoe1), .ADin(adin));
  int n_chk = 0, n_fail = 0, cyc = 0;
  always @(posedge clock) cyc++;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Expected {ad,cs,wr,rd,ADoe,busy} after edge e of a transaction (e=1 is the latch edge, 0 = idle).
  function automatic logic [5:0] bus_exp(int e, int ta, int tg, int td, logic r);
    int s;
    logic a, c, w, d, o, b;
    s = ta + tg + td;
    a = !(e >= 2 && e < 7 + ta);
    c = !((e >= 3 && e < 6 + ta) || (e >= 8 + ta + tg && e < 11 + s));
    w = !((e >= 4 && e < 5 + ta) || (!r && e >= 9 + ta + tg && e < 10 + s));
    d = !(r && e >= 9 + ta + tg && e < 10 + s);
    o = (e >= 5 && e < 8 + ta) || (!r && e >= 10 + ta + tg && e < 12 + s);
    b = e >= 1 && e < 13 + s;
    return {a, c, w, d, o, b};
  endfunction
  function automatic int pick(logic [2:0] r, int p);
    for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction
  int m_e = 0, m_ptr = 0, m_win = 0;
  logic m_rnw = 1'b0;
  logic [7:0] m_addr = '0, m_wdata = '0, m_adout = '0, m_rdata = '0;
  always @(posedge clock) begin
    if (reset) begin
      m_e = 0; m_ptr = 0; m_adout = '0; m_rdata = '0;
    end else if (m_e == 0) begin
      if (req != 0) begin
        m_win   = pick(req, m_ptr);
        m_rnw   = rnw[m_win];
        m_addr  = addr[8*m_win +: 8];
        m_wdata = wdata[8*m_win +: 8];
        m_e     = 1;
`ifdef RTC_ARB_RR_EN
        m_ptr   = (m_win + 1) % NREQ;
`endif
      end
    end else begin
      m_e++;
      if (m_e == 5) m_adout = m_addr;
      if (!m_rnw && m_e == 10 + TA + TG) m_adout = m_wdata;
      if (m_rnw && m_e == 10 + S) m_rdata = adin;
      if (m_e == 13 + S) m_e = 0;
    end
    #1;
    check("bus", 32'({ad, cs, wr, rd, adoe, busy}), 32'(bus_exp(m_e, TA, TG, TD, m_rnw)));
    check("gnt", 32'(gnt), (m_e >= 1 && m_e < 12 + S) ? 32'(1 << m_win) : 0);
    check("done", 32'(done), (m_e == 12 + S) ? 32'(1 << m_win) : 0);
    check("adout", 32'(adout), 32'(m_adout));
    check("rdata", 32'(rdata), 32'(m_rdata));
  end
  task automatic wait_done(output logic [2:0] d);
    int n;
    n = 0;
    d = '0;
    while (d == 0 && n < 200) begin
      @(negedge clock);
      d = done;
      n++;
    end
    if (d == 0) begin
      n_chk++; n_fail++;
      $display("FAIL done_timeout: got no done within 200 cycles at %0t", $time);
    end
  endtask
  typedef struct {
    logic [2:0] rq, rw;
    logic [23:0] a, wd;
    logic [7:0] di;
    logic [2:0] exp_done;
    logic [7:0] exp_rd;
  } vec_t;
  vec_t tv[6];
  initial begin
    logic [2:0] d, nb;
    int t_prev, n;
    logic [2:0] order[5];
    tv[0] = '{3'b001, 3'b000, 24'h000000, 24'h000038, 8'h00, 3'b001, 8'h00};
    tv[1] = '{3'b100, 3'b100, 24'h0A0000, 24'h000000, 8'h5C, 3'b100, 8'h5C};
    tv[2] = '{3'b010, 3'b000, 24'h001100, 24'h00A500, 8'h00, 3'b010, 8'h5C};
`ifdef RTC_ARB_RR_EN
    tv[3] = '{3'b111, 3'b000, 24'h030201, 24'h665544, 8'h00, 3'b100, 8'h5C};
    tv[4] = '{3'b110, 3'b000, 24'h070605, 24'h998877, 8'h00, 3'b010, 8'h5C};
    tv[5] = '{3'b101, 3'b101, 24'h0C0B0A, 24'h000000, 8'h3C, 3'b100, 8'h3C};
    order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
`else
    tv[3] = '{3'b111, 3'b000, 24'h030201, 24'h665544, 8'h00, 3'b001, 8'h5C};
    tv[4] = '{3'b110, 3'b000, 24'h070605, 24'h998877, 8'h00, 3'b010, 8'h5C};
    tv[5] = '{3'b101, 3'b101, 24'h0C0B0A, 24'h000000, 8'h3C, 3'b001, 8'h3C};
    order = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010};
`endif
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      rnw = tv[i].rw; addr = tv[i].a; wdata = tv[i].wd; adin = tv[i].di; req = tv[i].rq;
      wait_done(d);
      check($sformatf("tbl%0d_done", i), 32'(d), 32'(tv[i].exp_done));
      check($sformatf("tbl%0d_rdata", i), 32'(rdata), 32'(tv[i].exp_rd));
      req = '0;
    end
    // All three requesting continuously: grant order and done spacing.
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    rnw = '0; req = 3'b111;
    t_prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_done(d);
      check($sformatf("hold%0d_order", i), 32'(d), 32'(order[i]));
      if (i > 0) check($sformatf("hold%0d_spacing", i), cyc - t_prev, 13 + S);
      t_prev = cyc;
      if (i == 3) req[0] = 1'b0;
    end
    req = '0;
    // Reset in the middle of a write address phase.
    @(negedge clock);
    addr = 24'h000022; wdata = 24'h000077; rnw = '0; req = 3'b001;
    n = 0;
    while (m_e != 9 && n < 100) begin @(negedge clock); n++; end
    check("rst_reach_edge9", m_e, 9);
    reset = 1'b1;
    @(negedge clock);
    check("rst_bus", 32'({ad, cs, wr, rd, adoe}), 32'(5'b11110));
    check("rst_gnt", 32'(gnt), 0);
    reset = 1'b0;
    @(negedge clock);
    check("rst_relatch", 32'(gnt), 32'(3'b001));
    wait_done(d);
    check("rst_done", 32'(d), 32'(3'b001));
    req = '0;
    // Minimum timing build, requester 1 writing.
    @(negedge clock);
    addr1 = 24'h005A00; wdata1 = 24'h00C300; rnw1 = '0; req1 = 3'b010;
    for (int e = 1; e <= 16; e++) begin
      @(posedge clock); #1;
      check($sformatf("t1_bus_e%0d", e), 32'({ad1, cs1, wr1, rd1, adoe1, busy1}), 32'(bus_exp(e, 1, 1, 1, 1'b0)));
      check($sformatf("t1_done_e%0d", e), 32'(done1), (e == 15) ? 32'(3'b010) : 0);
      if (e == 5) check("t1_adout_addr", 32'(adout1), 32'h5A);
      if (e == 12) check("t1_adout_data", 32'(adout1), 32'hC3);
      if (e == 2) req1 = '0;
    end
    // Random traffic; the timeline model checks every cycle.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clock);
      adin = 8'($urandom); addr = 24'($urandom); wdata = 24'($urandom);
      nb = ($urandom_range(0, 9) == 0) ? (3'($urandom) & ~req) : 3'b000;
      rnw = (rnw & ~nb) | (3'($urandom) & nb);
      req = (req & ~done) | nb;
    end
    req = '0;
    repeat (40) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
